// File: rtl/conv_pkg.sv
// Shared definitions for the convolution frame sequencer.
// Holds the default layer geometry, the sequencer state type and the derived
// output-map size. NUM_FILTERS sizes nothing in the sequencer. It is kept here
// so that post-processing can import it from the same place.
package conv_pkg;

  localparam int unsigned IMG_W       = 28;
  localparam int unsigned IMG_H       = 28;
  localparam int unsigned KERNEL      = 5;
  localparam int unsigned PIPE_LAT    = 4;
  localparam int unsigned NUM_FILTERS = 6;

  localparam int unsigned OUT_W = IMG_W - KERNEL + 1;
  localparam int unsigned OUT_H = IMG_H - KERNEL + 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/conv_valid_pipe.sv
// Enable-gated valid shift register that mirrors the conv MAC pipeline.
// Ports:
//   clk_i, rst_ni  : clock and asynchronous active-low reset
//   en_i           : pipeline clock enable; stages only move when high
//   valid_i        : stage-0 input (window accepted this cycle)
//   valid_o        : last stage (MAC result valid)
//   empty_next_o   : no stage will hold a valid after the coming edge
module conv_valid_pipe #(
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic valid_i,
  output logic valid_o,
  output logic empty_next_o
);

  logic [Depth-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = stage_q;
    if (en_i) begin
      stage_d = (stage_q << 1) | Depth'(valid_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign valid_o      = stage_q[Depth-1];
  // Looks at the next-state contents so that the drain can finish in the same
  // edge that retires the last result.
  assign empty_next_o = ~|stage_d;

endmodule

// File: rtl/conv_frame_sequencer.sv
// Frame sequencer for one convolution layer over one input frame.
// It gates input FIFO pops and line-buffer shifts. It tracks the row and
// column of every consumed pixel and flags pixels that complete a KxK window.
// It carries window validity through the MAC pipeline and stalls the
// datapath whenever post-processing holds off a result.
// Ports:
//   i_clk, i_rst         : clock and asynchronous active-low reset
//   i_start              : frame start pulse; only honoured while idle
//   i_feat_valid         : input FIFO has a pixel (first-word fall-through)
//   o_feat_rd_en         : FIFO pop request
//   o_shift_en           : line buffer shift, one per consumed pixel
//   o_win_valid          : consumed pixel completes a window
//   o_pipe_en            : MAC pipeline clock enable
//   o_out_valid          : result valid; i_out_ready accepts it
//   o_out_row/o_out_col  : output-map coordinate of the current result
//   o_frame_last         : current result is the last one of the frame
//   o_busy, o_done       : frame in progress / one-cycle completion pulse
// Optional build macro CONV_SEQ_STATS_EN adds two saturating 32-bit counters:
//   o_stall_cycles (busy cycles with the pipe stalled) and
//   o_bubble_cycles (stream cycles that requested a pixel but got none).
module conv_frame_sequencer #(
  parameter int unsigned IMG_W    = conv_pkg::IMG_W,
  parameter int unsigned IMG_H    = conv_pkg::IMG_H,
  parameter int unsigned KERNEL   = conv_pkg::KERNEL,
  parameter int unsigned PIPE_LAT = conv_pkg::PIPE_LAT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_feat_valid,
  output logic                     o_feat_rd_en,
  output logic                     o_shift_en,
  output logic                     o_win_valid,
  output logic                     o_pipe_en,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(IMG_H)-1:0] o_out_row,
  output logic [$clog2(IMG_W)-1:0] o_out_col,
  output logic                     o_frame_last,
  output logic                     o_busy,
  output logic                     o_done
`ifdef CONV_SEQ_STATS_EN
  ,
  output logic [31:0]              o_stall_cycles,
  output logic [31:0]              o_bubble_cycles
`endif
);

  import conv_pkg::*;

  localparam int unsigned RowW = $clog2(IMG_H);
  localparam int unsigned ColW = $clog2(IMG_W);

  localparam logic [RowW-1:0] LastRow    = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] LastCol    = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] WinRow     = RowW'(KERNEL - 1);
  localparam logic [ColW-1:0] WinCol     = ColW'(KERNEL - 1);
  localparam logic [RowW-1:0] OutLastRow = RowW'(IMG_H - KERNEL);
  localparam logic [ColW-1:0] OutLastCol = ColW'(IMG_W - KERNEL);

  seq_state_t state_q, state_d;

  logic [RowW-1:0] row_q, row_d, out_row_q, out_row_d;
  logic [ColW-1:0] col_q, col_d, out_col_q, out_col_d;

  logic pipe_en, consume, win_valid, out_valid, out_accept;
  logic start_frame, last_pixel, pipe_empty_next;

  // ---------------------------------------------------------------------------
  // Valid pipe tracking the MAC datapath
  // ---------------------------------------------------------------------------
  conv_valid_pipe #(
    .Depth (PIPE_LAT)
  ) u_valid_pipe (
    .clk_i        (i_clk),
    .rst_ni       (i_rst),
    .en_i         (pipe_en),
    .valid_i      (win_valid),
    .valid_o      (out_valid),
    .empty_next_o (pipe_empty_next)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = STREAM;
      STREAM:  if (consume && last_pixel) state_d = DRAIN;
      DRAIN:   if (pipe_empty_next) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    // A held result freezes the whole datapath, FIFO reads included.
    pipe_en      = !out_valid || i_out_ready;
    start_frame  = (state_q == IDLE) && i_start;
    o_feat_rd_en = (state_q == STREAM) && pipe_en;
    consume      = o_feat_rd_en && i_feat_valid;
    last_pixel   = (row_q == LastRow) && (col_q == LastCol);
    win_valid    = consume && (row_q >= WinRow) && (col_q >= WinCol);
    out_accept   = out_valid && i_out_ready;

    o_shift_en   = consume;
    o_win_valid  = win_valid;
    // Forced low while reset is asserted so that every output reads 0.
    o_pipe_en    = pipe_en && i_rst;
    o_out_valid  = out_valid;
    o_out_row    = out_row_q;
    o_out_col    = out_col_q;
    o_frame_last = out_valid && (out_row_q == OutLastRow) && (out_col_q == OutLastCol);
    o_busy       = (state_q == STREAM) || (state_q == DRAIN);
    o_done       = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Input pixel and output result coordinate counters
  // ---------------------------------------------------------------------------
  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    out_row_d = out_row_q;
    out_col_d = out_col_q;

    if (start_frame) begin
      row_d     = '0;
      col_d     = '0;
      out_row_d = '0;
      out_col_d = '0;
    end else begin
      if (consume) begin
        if (col_q == LastCol) begin
          col_d = '0;
          row_d = (row_q == LastRow) ? '0 : row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
      end
      if (out_accept) begin
        if (out_col_q == OutLastCol) begin
          out_col_d = '0;
          out_row_d = (out_row_q == OutLastRow) ? '0 : out_row_q + RowW'(1);
        end else begin
          out_col_d = out_col_q + ColW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      row_q     <= '0;
      col_q     <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
    end else begin
      row_q     <= row_d;
      col_q     <= col_d;
      out_row_q <= out_row_d;
      out_col_q <= out_col_d;
    end
  end

`ifdef CONV_SEQ_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] stall_q, stall_d, bubble_q, bubble_d;

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (start_frame) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (o_busy && !pipe_en && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
      if (o_feat_rd_en && !i_feat_valid && (bubble_q != '1)) begin
        bubble_d = bubble_q + 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign o_stall_cycles  = stall_q;
  assign o_bubble_cycles = bubble_q;
`endif

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// Directed and randomized frame bench for conv_frame_sequencer, small geometry
// (6x6 frame, 3x3 kernel, pipe latency 2). The reference model tracks a frame
// as counts (pixels consumed, results delivered) and a queue of in-flight
// windows, each with the number of enabled cycles left before it emerges.
module tb_conv_frame_sequencer;

  localparam int W    = 6;
  localparam int H    = 6;
  localparam int K    = 3;
  localparam int L    = 2;
  localparam int OW   = W - K + 1;
  localparam int OH   = H - K + 1;
  localparam int NPIX = W * H;
  localparam int NRES = OW * OH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       feat_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic       feat_rd_en, shift_en, win_valid, pipe_en, out_valid;
  logic       frame_last, busy, done;
  logic [2:0] out_row, out_col;
`ifdef CONV_SEQ_STATS_EN
  logic [31:0] stall_cycles, bubble_cycles;
`endif

  always #5 clk = ~clk;

  conv_frame_sequencer #(
    .IMG_W    (W),
    .IMG_H    (H),
    .KERNEL   (K),
    .PIPE_LAT (L)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_start         (start),
    .i_feat_valid    (feat_valid),
    .o_feat_rd_en    (feat_rd_en),
    .o_shift_en      (shift_en),
    .o_win_valid     (win_valid),
    .o_pipe_en       (pipe_en),
    .o_out_valid     (out_valid),
    .i_out_ready     (out_ready),
    .o_out_row       (out_row),
    .o_out_col       (out_col),
    .o_frame_last    (frame_last),
    .o_busy          (busy),
    .o_done          (done)
`ifdef CONV_SEQ_STATS_EN
    ,
    .o_stall_cycles  (stall_cycles),
    .o_bubble_cycles (bubble_cycles)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit m_active = 0;
  bit m_done = 0;
  int m_consumed = 0;
  int m_results = 0;
  int m_stall = 0;
  int m_bubble = 0;
  int pend[$];

  // Observed per-frame tallies from the DUT
  int d_shifts, d_wins, d_results;
  bit d_done_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_active = 0;
    m_done = 0;
    m_consumed = 0;
    m_results = 0;
    m_stall = 0;
    m_bubble = 0;
    pend.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd"}, feat_rd_en, 0);
    check({tag, "_shift"}, shift_en, 0);
    check({tag, "_win"}, win_valid, 0);
    check({tag, "_pipe"}, pipe_en, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_row"}, out_row, 0);
    check({tag, "_col"}, out_col, 0);
    check({tag, "_last"}, frame_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model to
  // the rising edge, then return 1 time unit after it.
  task automatic tick(input bit st, input bit fv, input bit rdy);
    bit idle, ov, pen, streaming, rd, sh, wv;
    int r, c;
    start = st;
    feat_valid = fv;
    out_ready = rdy;
    @(negedge clk);
    idle      = !m_active && !m_done;
    ov        = (pend.size() > 0) && (pend[0] == 0);
    pen       = !ov || rdy;
    streaming = m_active && (m_consumed < NPIX);
    rd        = streaming && pen;
    sh        = rd && fv;
    r         = m_consumed / W;
    c         = m_consumed % W;
    wv        = sh && (r >= K - 1) && (c >= K - 1);

    check("rd_en", feat_rd_en, rd);
    check("shift_en", shift_en, sh);
    check("win_valid", win_valid, wv);
    check("pipe_en", pipe_en, pen);
    check("out_valid", out_valid, ov);
    check("busy", busy, m_active);
    check("done", done, m_done);
    if (ov) begin
      check("out_row", out_row, m_results / OW);
      check("out_col", out_col, m_results % OW);
      check("frame_last", frame_last, m_results == NRES - 1);
    end else begin
      check("frame_last_idle", frame_last, 0);
    end
`ifdef CONV_SEQ_STATS_EN
    if (m_done) begin
      check("stall_cycles", stall_cycles, m_stall);
      check("bubble_cycles", bubble_cycles, m_bubble);
    end
`endif

    d_shifts  += int'(shift_en);
    d_wins    += int'(win_valid);
    d_results += int'(out_valid && rdy);
    if (done) d_done_seen = 1;

    m_done = 0;
    if (idle && st) begin
      m_active = 1;
      m_consumed = 0;
      m_results = 0;
      m_stall = 0;
      m_bubble = 0;
      pend.delete();
    end else if (m_active) begin
      if (!pen) m_stall++;
      if (rd && !fv) m_bubble++;
      if (pen) begin
        if (ov) void'(pend.pop_front());
        foreach (pend[i]) pend[i]--;
        if (wv) pend.push_back(L - 1);
      end
      if (sh) m_consumed++;
      if (ov && rdy) begin
        m_results++;
        if (m_results == NRES) begin
          m_active = 0;
          m_done = 1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  // mode 0: continuous feed; 1: feed toggling; 2: random feed with one
  // 5-cycle backpressure; 3: mid-frame start pulses; 4: reset at pixel 20;
  // 5: random feed and random ready.
  task automatic run_frame(input int mode, input string tag);
    int cyc;
    int stall_left;
    bit stalled;
    bit fv, rdy, st;
    cyc = 0;
    stall_left = 0;
    stalled = 0;
    d_shifts = 0;
    d_wins = 0;
    d_results = 0;
    d_done_seen = 0;
    tick(1, 1, 1);
    while (!d_done_seen && cyc < 600) begin
      fv  = 1;
      rdy = 1;
      st  = 0;
      case (mode)
        1: fv = (cyc % 2 == 0);
        2: begin
          fv = ($urandom_range(0, 3) != 0);
          if (out_valid && !stalled) begin
            stalled = 1;
            stall_left = 5;
          end
          if (stall_left > 0) begin
            rdy = 0;
            stall_left--;
          end
        end
        3: st = (cyc % 7 == 3);
        5: begin
          fv  = ($urandom_range(0, 2) != 0);
          rdy = ($urandom_range(0, 3) != 0);
        end
        default: ;
      endcase
      tick(st, fv, rdy);
      cyc++;
      if (mode == 4 && d_shifts == 20) begin
        do_reset({tag, "_midrst"});
        return;
      end
    end
    check({tag, "_done_seen"}, d_done_seen, 1);
    check({tag, "_shifts"}, d_shifts, NPIX);
    check({tag, "_wins"}, d_wins, NRES);
    check({tag, "_results"}, d_results, NRES);
`ifdef CONV_SEQ_STATS_EN
    if (mode == 2) check({tag, "_stall5"}, stall_cycles, 5);
`endif
    tick(0, 0, 1);
    tick(0, 0, 1);
  endtask

  initial begin
    #1;
    check_all_zero("por");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tick(0, 1, 1);
    tick(0, 0, 0);

    run_frame(0, "cont");
    run_frame(1, "toggle");
    run_frame(2, "stall");
    run_frame(3, "midstart");
    run_frame(4, "abort");
    run_frame(0, "restart");
    run_frame(5, "rand_a");
    run_frame(5, "rand_b");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
